// File: rtl/lane_sched_pkg.sv
// Shared types, defaults and round-robin helper for lane_sched.
// Used by both the default build and LANE_SCHED_STATS_EN builds.
package lane_sched_pkg;

    typedef enum logic {
        LS_IDLE,
        LS_BUSY
    } lane_sched_state_e;

    localparam int LS_NREQ      = 3;
    localparam int LS_DW        = 8;
    localparam int LS_MAX_BEATS = 16;

    // Scan from farthest to nearest so the first set bit after ptr wins.
    function automatic logic [2:0] rr_pick(
        input logic [7:0] req,
        input logic [2:0] ptr,
        input int         n
    );
        logic [2:0] win;
        int         idx;
        win = '0;
        for (int k = 8; k >= 1; k--) begin
            if (k <= n) begin
                idx = (int'(ptr) + k) % n;
                if (req[idx]) win = idx[2:0];
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/lane_sched_rr.sv
// Combinational round-robin picker for lane_sched.
// Winner is the first requester after ptr, wrapping at NREQ.
module lane_sched_rr
    import lane_sched_pkg::*;
#(
    parameter int NREQ = LS_NREQ
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [$clog2(NREQ)-1:0] win_idx,
    output logic                    any
);

    localparam int IW = $clog2(NREQ);

    always_comb begin
        win_idx = IW'(rr_pick(8'(req), 3'(ptr), NREQ));
        any     = |req;
    end

endmodule

// File: rtl/lane_sched.sv
// Round-robin packet scheduler with registered output stage.
// Optional stats counters under `LANE_SCHED_STATS_EN.
module lane_sched
    import lane_sched_pkg::*;
#(
    parameter int NREQ      = LS_NREQ,
    parameter int DW        = LS_DW,
    parameter int MAX_BEATS = LS_MAX_BEATS
) (
    input  logic                    clk,
    input  logic                    rst_n,
`ifdef LANE_SCHED_STATS_EN
    input  logic                    stats_clr,
    output logic [0:NREQ-1][15:0]   grant_cnt,
    output logic [15:0]             trunc_cnt,
`endif
    input  logic [NREQ-1:0]         req_valid,
    input  logic [0:NREQ-1][DW-1:0] req_data,
    input  logic [NREQ-1:0]         req_last,
    output logic [NREQ-1:0]         req_ready,
    output logic                    out_valid,
    output logic [DW-1:0]           out_data,
    output logic                    out_last,
    output logic [$clog2(NREQ)-1:0] out_src,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    trunc_err
);

    localparam int IW = $clog2(NREQ);

    lane_sched_state_e state, state_nxt;

    logic [IW-1:0] gnt;
    logic [IW-1:0] ptr;
    logic [IW-1:0] win_idx;
    logic          any;
    logic [7:0]    cnt;
    logic          slot_free;
    logic          accept;
    logic          beat_last;
    logic          trunc_now;

    lane_sched_rr #(.NREQ(NREQ)) u_rr (
        .req     (req_valid),
        .ptr     (ptr),
        .win_idx (win_idx),
        .any     (any)
    );

    assign slot_free = out_ready | ~out_valid;
    assign busy      = (state == LS_BUSY);

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        accept    = 1'b0;
        beat_last = 1'b0;
        trunc_now = 1'b0;
        unique case (state)
            LS_IDLE: begin
                if (any) state_nxt = LS_BUSY;
            end
            LS_BUSY: begin
                req_ready[gnt] = slot_free;
                accept    = req_valid[gnt] & slot_free;
                beat_last = req_last[gnt]
                          | (cnt == 8'(MAX_BEATS - 1));
                if (accept & beat_last) begin
                    state_nxt = LS_IDLE;
                    trunc_now = ~req_last[gnt];
                end
            end
            default: state_nxt = LS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LS_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt       <= '0;
            ptr       <= IW'(NREQ - 1);
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_src   <= '0;
            trunc_err <= 1'b0;
        end else begin
            trunc_err <= trunc_now;
            if (state == LS_IDLE && any) begin
                gnt <= win_idx;
                cnt <= '0;
            end
            // Output register holds while the downstream stalls.
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= req_data[gnt];
                out_last  <= beat_last;
                out_src   <= gnt;
                cnt       <= cnt + 8'd1;
                if (beat_last) ptr <= gnt;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef LANE_SCHED_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt <= '0;
            trunc_cnt <= '0;
        end else if (stats_clr) begin
            grant_cnt <= '0;
            trunc_cnt <= '0;
        end else begin
            if (accept && beat_last && grant_cnt[gnt] != 16'hFFFF)
                grant_cnt[gnt] <= grant_cnt[gnt] + 16'd1;
            if (trunc_now && trunc_cnt != 16'hFFFF)
                trunc_cnt <= trunc_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lane_sched.sv
// Self-checking bench for lane_sched (MAX_BEATS=4).
// Stats checks run when LANE_SCHED_STATS_EN is defined.
module tb_lane_sched;

    localparam int NREQ = 3;
    localparam int DW   = 8;
    localparam int MB   = 4;

    typedef struct {
        logic [7:0] d;
        logic       l;
    } beat_t;

    typedef struct {
        logic [7:0] d;
        int         s;
        logic       l;
        int         t;
    } obs_t;

    logic                    clk = 0;
    logic                    rst_n = 0;
    logic [NREQ-1:0]         req_valid = '0;
    logic [0:NREQ-1][DW-1:0] req_data = '0;
    logic [NREQ-1:0]         req_last = '0;
    logic [NREQ-1:0]         req_ready;
    logic                    out_valid;
    logic [DW-1:0]           out_data;
    logic                    out_last;
    logic [1:0]              out_src;
    logic                    out_ready = 1;
    logic                    busy;
    logic                    trunc_err;
`ifdef LANE_SCHED_STATS_EN
    logic                    stats_clr = 0;
    logic [0:NREQ-1][15:0]   grant_cnt;
    logic [15:0]             trunc_cnt;
`endif

    lane_sched #(.NREQ(NREQ), .DW(DW), .MAX_BEATS(MB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef LANE_SCHED_STATS_EN
        .stats_clr (stats_clr),
        .grant_cnt (grant_cnt),
        .trunc_cnt (trunc_cnt),
`endif
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src),
        .out_ready (out_ready),
        .busy      (busy),
        .trunc_err (trunc_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    beat_t           qs[NREQ][$];
    logic [NREQ-1:0] en = '1;
    obs_t            got[$];
    int              cyc = 0;
    int              te_n = 0;
    logic [7:0]      te_d = '0;

    // Requester side: present queue heads, pop on handshake.
    always @(negedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (qs[i].size() > 0 && en[i]) begin
                req_valid[i] = 1'b1;
                req_data[i]  = qs[i][0].d;
                req_last[i]  = qs[i][0].l;
            end else begin
                req_valid[i] = 1'b0;
                req_data[i]  = '0;
                req_last[i]  = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < NREQ; i++)
            if (rst_n && req_valid[i] && req_ready[i] && qs[i].size() > 0)
                void'(qs[i].pop_front());
        if (rst_n && out_valid && out_ready)
            got.push_back('{d: out_data, s: int'(out_src),
                            l: out_last, t: cyc});
        if (rst_n && trunc_err) begin
            te_n++;
            te_d = out_data;
        end
    end

    // Reference model: grant holder, beats taken in the grant,
    // last winner, and the contents of the output slot.
    bit         m_busy;
    int         m_gnt;
    int         m_beats;
    int         m_ptr;
    bit         m_ov;
    logic [7:0] m_od;
    bit         m_ol;
    int         m_os;
    bit         m_te;
    bit         was_busy;
    bit         found;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_gnt = 0; m_beats = 0; m_ptr = NREQ - 1;
            m_ov = 0; m_od = 0; m_ol = 0; m_os = 0; m_te = 0;
        end else begin
            was_busy = m_busy;
            m_te = 0;
            if (was_busy && req_valid[m_gnt] && (out_ready || !m_ov)) begin
                m_beats++;
                m_ov = 1;
                m_od = req_data[m_gnt];
                m_os = m_gnt;
                m_ol = req_last[m_gnt] || (m_beats == MB);
                if (m_ol) begin
                    m_busy = 0;
                    m_ptr  = m_gnt;
                    m_te   = !req_last[m_gnt];
                end
            end else if (out_ready) begin
                m_ov = 0;
            end
            if (!was_busy && req_valid != 0) begin
                found = 0;
                for (int k = 1; k <= NREQ; k++) begin
                    if (!found && req_valid[(m_ptr + k) % NREQ]) begin
                        found   = 1;
                        m_gnt   = (m_ptr + k) % NREQ;
                        m_busy  = 1;
                        m_beats = 0;
                    end
                end
            end
        end
    end

    task automatic test_reset();
        logic [14:0] v;
        rst_n = 0;
        repeat (3) @(negedge clk);
        #1;
        v = {req_ready, out_valid, out_data, out_last,
             out_src, busy, trunc_err};
        checks++;
        if (v !== '0)
            $display("FAIL reset_values: got %h want 0", v);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || req_ready !== '0)
            $display("FAIL idle_no_req: busy=%b ready=%b want 0/0",
                     busy, req_ready);
        if (busy !== 1'b0 || req_ready !== '0) errors++;
        if (v !== '0) errors++;
    endtask

    task automatic test_two_packets();
        logic [7:0] ed[6] = '{8'h10, 8'h11, 8'h12, 8'h30, 8'h31, 8'h32};
        int         es[6] = '{0, 0, 0, 2, 2, 2};
        got.delete();
        te_n = 0;
        for (int k = 0; k < 3; k++) begin
            qs[0].push_back('{d: 8'(8'h10 + k), l: (k == 2)});
            qs[2].push_back('{d: 8'(8'h30 + k), l: (k == 2)});
        end
        for (int k = 0; k < 200 && got.size() < 6; k++) @(negedge clk);
        checks++;
        if (got.size() != 6) begin
            errors++;
            $display("FAIL two_pkt_count: got %0d want 6", got.size());
        end else begin
            for (int n = 0; n < 6; n++) begin
                checks++;
                if (got[n].d !== ed[n] || got[n].s != es[n] ||
                    got[n].l !== (n == 2 || n == 5)) begin
                    errors++;
                    $display("FAIL two_pkt_beat%0d: got d=%h s=%0d l=%b want d=%h s=%0d l=%b",
                             n, got[n].d, got[n].s, got[n].l,
                             ed[n], es[n], (n == 2 || n == 5));
                end
            end
            checks++;
            if (got[1].t - got[0].t != 1 || got[3].t - got[2].t != 2) begin
                errors++;
                $display("FAIL two_pkt_spacing: got %0d/%0d want 1/2",
                         got[1].t - got[0].t, got[3].t - got[2].t);
            end
        end
        checks++;
        if (te_n != 0) begin
            errors++;
            $display("FAIL two_pkt_trunc: got %0d pulses want 0", te_n);
        end
    endtask

    task automatic test_round_robin();
        got.delete();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < NREQ; i++)
                qs[i].push_back('{d: 8'(8'hA0 + 16 * k + i), l: 1'b1});
        for (int k = 0; k < 200 && got.size() < 6; k++) @(negedge clk);
        checks++;
        if (got.size() != 6) begin
            errors++;
            $display("FAIL rr_count: got %0d want 6", got.size());
        end else begin
            for (int n = 0; n < 6; n++) begin
                checks++;
                if (got[n].s != n % 3 ||
                    got[n].d !== 8'(8'hA0 + 16 * (n / 3) + n % 3) ||
                    (n > 0 && got[n].t - got[n-1].t != 2)) begin
                    errors++;
                    $display("FAIL rr_beat%0d: got s=%0d d=%h want s=%0d d=%h gap 2",
                             n, got[n].s, got[n].d, n % 3,
                             8'(8'hA0 + 16 * (n / 3) + n % 3));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] held;
        got.delete();
        for (int k = 0; k < 3; k++)
            qs[1].push_back('{d: 8'(8'h50 + k), l: (k == 2)});
        for (int k = 0; k < 200 && got.size() < 1; k++) @(negedge clk);
        out_ready = 0;
        #1;
        held = out_data;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) begin
                @(negedge clk);
                #1;
            end
            checks++;
            if (out_valid !== 1'b1 || out_data !== held ||
                req_ready !== '0) begin
                errors++;
                $display("FAIL stall_c%0d: got v=%b d=%h rdy=%b want 1 %h 000",
                         c, out_valid, out_data, req_ready, held);
            end
        end
        @(negedge clk);
        out_ready = 1;
        for (int k = 0; k < 200 && got.size() < 3; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        checks++;
        if (got.size() != 3) begin
            errors++;
            $display("FAIL stall_count: got %0d want 3", got.size());
        end else begin
            for (int n = 0; n < 3; n++) begin
                checks++;
                if (got[n].d !== 8'(8'h50 + n) || got[n].s != 1 ||
                    got[n].l !== (n == 2)) begin
                    errors++;
                    $display("FAIL stall_beat%0d: got d=%h s=%0d l=%b want d=%h s=1",
                             n, got[n].d, got[n].s, got[n].l, 8'(8'h50 + n));
                end
            end
        end
    endtask

    task automatic test_truncation();
        got.delete();
        te_n = 0;
        for (int k = 0; k < 6; k++)
            qs[1].push_back('{d: 8'(8'h60 + k), l: (k == 5)});
        for (int k = 0; k < 300 && got.size() < 6; k++) @(negedge clk);
        repeat (2) @(negedge clk);
        checks++;
        if (got.size() != 6) begin
            errors++;
            $display("FAIL trunc_count: got %0d want 6", got.size());
        end else begin
            for (int n = 0; n < 6; n++) begin
                checks++;
                if (got[n].d !== 8'(8'h60 + n) ||
                    got[n].l !== (n == 3 || n == 5)) begin
                    errors++;
                    $display("FAIL trunc_beat%0d: got d=%h l=%b want d=%h l=%b",
                             n, got[n].d, got[n].l, 8'(8'h60 + n),
                             (n == 3 || n == 5));
                end
            end
            checks++;
            if (got[4].t - got[3].t != 2) begin
                errors++;
                $display("FAIL trunc_rearb: got gap %0d want 2",
                         got[4].t - got[3].t);
            end
        end
        checks++;
        if (te_n != 1 || te_d !== 8'h63) begin
            errors++;
            $display("FAIL trunc_pulse: got n=%0d d=%h want 1 63", te_n, te_d);
        end
    endtask

    task automatic test_reset_mid_packet();
        logic [14:0] v;
        got.delete();
        for (int k = 0; k < 3; k++)
            qs[1].push_back('{d: 8'(8'h70 + k), l: (k == 2)});
        for (int k = 0; k < 200 && got.size() < 1; k++) @(negedge clk);
        #2;
        rst_n = 0;
        #1;
        v = {req_ready, out_valid, out_data, out_last,
             out_src, busy, trunc_err};
        checks++;
        if (v !== '0) begin
            errors++;
            $display("FAIL async_reset: got %h want 0", v);
        end
        for (int i = 0; i < NREQ; i++) qs[i].delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        got.delete();
        qs[2].push_back('{d: 8'h92, l: 1'b1});
        qs[0].push_back('{d: 8'h90, l: 1'b1});
        for (int k = 0; k < 200 && got.size() < 2; k++) @(negedge clk);
        checks++;
        if (got.size() != 2 || got[0].s != 0 || got[0].d !== 8'h90 ||
            got[1].s != 2) begin
            errors++;
            $display("FAIL post_reset_order: got n=%0d want src 0 then 2",
                     got.size());
        end
    endtask

    task automatic test_random();
        int len;
        logic [14:0] v;
        logic [14:0] e;
        logic [NREQ-1:0] er;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            en        = NREQ'($urandom);
            out_ready = ($urandom % 4) != 0;
            for (int i = 0; i < NREQ; i++) begin
                if (qs[i].size() < 8 && $urandom % 5 == 0) begin
                    len = $urandom_range(1, 6);
                    for (int k = 0; k < len; k++)
                        qs[i].push_back('{d: 8'($urandom),
                                          l: (k == len - 1) &&
                                             ($urandom % 5 != 0)});
                end
            end
            #1;
            er = '0;
            if (m_busy && (out_ready || !m_ov)) er[m_gnt] = 1'b1;
            v = {req_ready, out_valid, out_data, out_last,
                 out_src, busy, trunc_err};
            e = {er, m_ov, m_od, m_ol, 2'(m_os), m_busy, m_te};
            checks++;
            if (v !== e) begin
                errors++;
                $display("FAIL rand_c%0d: got %h want %h", c, v, e);
            end
        end
        @(negedge clk);
        en = '1;
        out_ready = 1;
        for (int i = 0; i < NREQ; i++)
            qs[i].push_back('{d: 8'hEE, l: 1'b1});
        for (int k = 0; k < 2000 &&
             (qs[0].size() + qs[1].size() + qs[2].size() != 0 ||
              busy || out_valid); k++)
            @(negedge clk);
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rand_drain: got busy=%b v=%b want 0/0",
                     busy, out_valid);
        end
    endtask

`ifdef LANE_SCHED_STATS_EN
    task automatic test_stats();
        @(negedge clk);
        stats_clr = 1;
        @(negedge clk);
        stats_clr = 0;
        got.delete();
        for (int p = 0; p < 3; p++)
            for (int k = 0; k < 2; k++)
                qs[1].push_back('{d: 8'(8'hC0 + 2 * p + k), l: (k == 1)});
        for (int k = 0; k < 4; k++)
            qs[1].push_back('{d: 8'(8'hD0 + k), l: 1'b0});
        for (int k = 0; k < 300 && got.size() < 10; k++) @(negedge clk);
        repeat (2) @(negedge clk);
        checks++;
        if (grant_cnt[1] !== 16'd4 || trunc_cnt !== 16'd1 ||
            grant_cnt[0] !== 16'd0) begin
            errors++;
            $display("FAIL stats_cnt: got g1=%0d t=%0d g0=%0d want 4 1 0",
                     grant_cnt[1], trunc_cnt, grant_cnt[0]);
        end
        qs[0].push_back('{d: 8'hF0, l: 1'b1});
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            #1;
            if (req_valid[0] && req_ready[0]) begin
                stats_clr = 1;
                break;
            end
        end
        @(negedge clk);
        stats_clr = 0;
        repeat (2) @(negedge clk);
        checks++;
        if (grant_cnt !== '0 || trunc_cnt !== '0) begin
            errors++;
            $display("FAIL stats_clr: got g=%h t=%0d want 0",
                     grant_cnt, trunc_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_two_packets();
        test_round_robin();
        test_backpressure();
        test_truncation();
        test_reset_mid_packet();
        test_random();
`ifdef LANE_SCHED_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
